// File: rtl/podule_cycle.sv
// Podule bus cycle controller: synchronises host strobes, latches the address,
// issues single-clock read/write strobes and holds the host via iogt until done.
module podule_cycle #(
    parameter int WAIT_CYCLES = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps_n,
    input  logic        ior_n,
    input  logic        iow_n,
    input  logic [11:0] la,
    output logic [11:0] a,
    output logic        cyc,
    output logic        rd_stb,
    output logic        wr_stb,
    output logic        iogt,
    output logic        timeout,
    input  logic        timeout_clr
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LATCH   = 3'd1,
        S_ACTIVE  = 3'd2,
        S_WAIT    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [7:0] TO_LIMIT  = 8'(TIMEOUT);

    state_t     state;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic       dir;
    logic [3:0] wait_cnt;
    logic [7:0] to_cnt;

    logic       sel;
    logic       rd;
    logic       wr;
    logic       hold;
    logic [7:0] to_next;

    // Bit order in the synchronisers: {iow_n, ior_n, ps_n}.
    assign sel     = ~sync2[0];
    assign rd      = ~sync2[1];
    assign wr      = ~sync2[2];
    assign hold    = sel & (dir ? wr : rd);
    assign to_next = to_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 3'b111;
            sync2    <= 3'b111;
            state    <= S_IDLE;
            a        <= '0;
            cyc      <= 1'b0;
            rd_stb   <= 1'b0;
            wr_stb   <= 1'b0;
            iogt     <= 1'b1;
            timeout  <= 1'b0;
            dir      <= 1'b0;
            wait_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            sync1  <= {iow_n, ior_n, ps_n};
            sync2  <= sync1;
            rd_stb <= 1'b0;
            wr_stb <= 1'b0;
            // A timeout set later in this block overrides the clear.
            if (timeout_clr) timeout <= 1'b0;

            case (state)
                S_IDLE: begin
                    iogt <= 1'b1;
                    cyc  <= 1'b0;
                    if (sel && (rd || wr)) begin
                        a      <= la;
                        cyc    <= 1'b1;
                        iogt   <= 1'b0;
                        dir    <= wr & ~rd;
                        to_cnt <= '0;
                        state  <= S_LATCH;
                    end
                end

                S_LATCH: begin
                    if (!hold) begin
                        iogt  <= 1'b1;
                        cyc   <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        rd_stb <= ~dir;
                        wr_stb <= dir;
                        state  <= S_ACTIVE;
                    end
                end

                S_ACTIVE, S_WAIT: begin
                    if (!hold) begin
                        iogt  <= 1'b1;
                        cyc   <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_next;
                        if (to_next == TO_LIMIT) begin
                            timeout <= 1'b1;
                            iogt    <= 1'b1;
                            state   <= S_RELEASE;
                        end else if (state == S_ACTIVE) begin
                            wait_cnt <= WAIT_LOAD;
                            if (WAIT_LOAD == 4'd0) begin
                                iogt  <= 1'b1;
                                state <= S_RELEASE;
                            end else begin
                                state <= S_WAIT;
                            end
                        end else begin
                            wait_cnt <= wait_cnt - 4'd1;
                            if (wait_cnt == 4'd1) begin
                                iogt  <= 1'b1;
                                state <= S_RELEASE;
                            end
                        end
                    end
                end

                S_RELEASE: begin
                    // Host keeps the strobe low after iogt; wait for it to let go.
                    iogt <= 1'b1;
                    if (!hold) begin
                        cyc   <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    iogt  <= 1'b1;
                    cyc   <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_podule_cycle.sv
// Bench for podule_cycle: table vectors, randomized transactions against a timing
// model, plus reset, held-strobe and timeout sequences.
module tb_podule_cycle;

    localparam int W = 4;

    typedef struct {
        int rd_clk;
        int rd_cnt;
        int wr_clk;
        int wr_cnt;
        int iogt_lo;
        int iogt_hi;
        int cyc_on;
        int cyc_off;
        bit a_ok;
        bit overlap;
        bit to_seen;
    } obs_t;

    typedef struct {
        int rd_clk;
        int wr_clk;
        int iogt_hi;
        int cyc_off;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [11:0] addr;
        int          rel;
        logic        ps_only;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps_n, ior_n, iow_n, timeout_clr;
    logic [11:0] la;
    logic [11:0] a, a_t;
    logic        cyc, rd_stb, wr_stb, iogt, timeout;
    logic        cyc_t, rd_stb_t, wr_stb_t, iogt_t, timeout_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [11:0] exp_q[$];

    podule_cycle #(.WAIT_CYCLES(W), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .ps_n(ps_n), .ior_n(ior_n), .iow_n(iow_n), .la(la),
        .a(a), .cyc(cyc), .rd_stb(rd_stb), .wr_stb(wr_stb), .iogt(iogt),
        .timeout(timeout), .timeout_clr(timeout_clr)
    );

    podule_cycle #(.WAIT_CYCLES(15), .TIMEOUT(8)) dut_to (
        .clk(clk), .rst(rst), .ps_n(ps_n), .ior_n(ior_n), .iow_n(iow_n), .la(la),
        .a(a_t), .cyc(cyc_t), .rd_stb(rd_stb_t), .wr_stb(wr_stb_t), .iogt(iogt_t),
        .timeout(timeout_t), .timeout_clr(timeout_clr)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Timing model: host asserts at clock 0 and drops at clock rel; the drop
    // reaches the controller after two sync clocks and one FSM clock.
    function automatic exp_t model(input logic rd_i, input int rel);
        exp_t m;
        int   fin;
        fin       = rel + 3;
        m.rd_clk  = -1;
        m.wr_clk  = -1;
        if (fin > 4) begin
            if (rd_i) m.rd_clk = 4;
            else      m.wr_clk = 4;
        end
        m.iogt_hi = (fin < 4 + W) ? fin : 4 + W;
        m.cyc_off = fin;
        return m;
    endfunction

    // Driver: one host cycle, observing the default-config DUT every clock.
    task automatic run_txn(input logic rd_i, input logic wr_i, input logic [11:0] addr,
                           input int rel, input logic ps_only, output obs_t o);
        o = '{rd_clk: -1, rd_cnt: 0, wr_clk: -1, wr_cnt: 0, iogt_lo: -1, iogt_hi: -1,
              cyc_on: -1, cyc_off: -1, a_ok: 1'b1, overlap: 1'b0, to_seen: 1'b0};
        tick();
        la    = addr;
        ps_n  = 1'b0;
        ior_n = ~rd_i;
        iow_n = ~wr_i;
        for (int t = 1; t <= rel + 11; t++) begin
            tick();
            if (rd_stb) begin o.rd_cnt++; if (o.rd_clk < 0) o.rd_clk = t; end
            if (wr_stb) begin o.wr_cnt++; if (o.wr_clk < 0) o.wr_clk = t; end
            if (rd_stb && wr_stb) o.overlap = 1'b1;
            if (!iogt && o.iogt_lo < 0) o.iogt_lo = t;
            if (iogt && o.iogt_lo >= 0 && o.iogt_hi < 0) o.iogt_hi = t;
            if (cyc && o.cyc_on < 0) o.cyc_on = t;
            if (!cyc && o.cyc_on >= 0 && o.cyc_off < 0) o.cyc_off = t;
            if (t >= 3 && a !== addr) o.a_ok = 1'b0;
            if (timeout) o.to_seen = 1'b1;
            if (t == 4) la = 12'($urandom);
            if (t == rel) begin
                ps_n = 1'b1;
                if (!ps_only) begin ior_n = 1'b1; iow_n = 1'b1; end
            end
            if (t == rel + 8) begin ior_n = 1'b1; iow_n = 1'b1; end
        end
    endtask

    task automatic compare(input string tag, input obs_t o, input exp_t e);
        check({tag, " rd_clk"},  o.rd_clk,  e.rd_clk);
        check({tag, " rd_cnt"},  o.rd_cnt,  (e.rd_clk >= 0) ? 1 : 0);
        check({tag, " wr_clk"},  o.wr_clk,  e.wr_clk);
        check({tag, " wr_cnt"},  o.wr_cnt,  (e.wr_clk >= 0) ? 1 : 0);
        check({tag, " iogt_lo"}, o.iogt_lo, 3);
        check({tag, " iogt_hi"}, o.iogt_hi, e.iogt_hi);
        check({tag, " cyc_on"},  o.cyc_on,  3);
        check({tag, " cyc_off"}, o.cyc_off, e.cyc_off);
        check({tag, " a_held"},  int'(o.a_ok), 1);
        check({tag, " overlap"}, int'(o.overlap), 0);
        check({tag, " timeout"}, int'(o.to_seen), 0);
    endtask

    task automatic txn_and_score(input string tag, input logic rd_i, input logic wr_i,
                                 input logic [11:0] addr, input int rel,
                                 input logic ps_only, input exp_t e);
        obs_t        o;
        logic [11:0] exp_a;
        exp_q.push_back(addr);
        run_txn(rd_i, wr_i, addr, rel, ps_only, o);
        compare(tag, o, e);
        exp_a = exp_q.pop_front();
        check({tag, " a_final"}, int'(a), int'(exp_a));
    endtask

    initial begin
        vec_t vecs[8];
        int   first;
        int   cnt;

        vecs[0] = '{1'b1, 1'b0, 12'h900, 12, 1'b0, '{4, -1, 8, 15}};
        vecs[1] = '{1'b0, 1'b1, 12'hC00, 10, 1'b0, '{-1, 4, 8, 13}};
        vecs[2] = '{1'b1, 1'b1, 12'h123,  9, 1'b0, '{4, -1, 8, 12}};
        vecs[3] = '{1'b1, 1'b0, 12'h456,  5, 1'b1, '{4, -1, 8, 8}};
        vecs[4] = '{1'b0, 1'b1, 12'h0AB,  3, 1'b0, '{-1, 4, 6, 6}};
        vecs[5] = '{1'b1, 1'b0, 12'hFFF,  1, 1'b0, '{-1, -1, 4, 4}};
        vecs[6] = '{1'b0, 1'b1, 12'h555,  8, 1'b0, '{-1, 4, 8, 11}};
        vecs[7] = '{1'b1, 1'b0, 12'h001,  2, 1'b1, '{4, -1, 5, 5}};

        // Reset state
        rst = 1'b1; ps_n = 1'b1; ior_n = 1'b1; iow_n = 1'b1;
        timeout_clr = 1'b0; la = 12'h000;
        repeat (3) tick();
        check("reset a",       int'(a), 0);
        check("reset cyc",     int'(cyc), 0);
        check("reset iogt",    int'(iogt), 1);
        check("reset strobes", int'({rd_stb, wr_stb}), 0);
        check("reset timeout", int'(timeout), 0);
        rst = 1'b0;
        repeat (2) tick();

        // Table-driven vectors
        foreach (vecs[i])
            txn_and_score($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                          vecs[i].rel, vecs[i].ps_only, vecs[i].e);

        // Randomized transactions against the model
        for (int n = 0; n < 40; n++) begin
            int          kind;
            int          rel;
            logic        rd_i, wr_i, pso;
            logic [11:0] addr;
            kind = $urandom_range(0, 2);
            rd_i = (kind != 1);
            wr_i = (kind != 0);
            rel  = $urandom_range(1, 14);
            pso  = 1'($urandom_range(0, 1));
            addr = 12'($urandom);
            txn_and_score($sformatf("rnd%0d", n), rd_i, wr_i, addr, rel, pso, model(rd_i, rel));
        end

        // Reset during an active write
        tick();
        la = 12'hABC; ps_n = 1'b0; iow_n = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        check("midrst iogt", int'(iogt), 1);
        check("midrst cyc",  int'(cyc), 0);
        check("midrst a",    int'(a), 0);
        tick();
        ps_n = 1'b1; iow_n = 1'b1;
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (rd_stb || wr_stb || cyc || !iogt) cnt++;
        end
        check("midrst quiet", cnt, 0);
        txn_and_score("postrst", 1'b0, 1'b1, 12'h3C3, 10, 1'b0, model(1'b0, 10));

        // Held strobe: one rd_stb only, then re-assert after release
        tick();
        la = 12'h200; ps_n = 1'b0; ior_n = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 58; k++) begin
            tick();
            if (rd_stb) cnt++;
        end
        check("held rd_cnt", cnt, 1);
        check("held iogt",   int'(iogt), 1);
        check("held cyc",    int'(cyc), 1);
        ior_n = 1'b1;
        repeat (6) tick();
        check("held cyc_off", int'(cyc), 0);
        ior_n = 1'b0;
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (rd_stb && first < 0) first = k;
        end
        check("held second rd_stb", first, 4);
        ps_n = 1'b1; ior_n = 1'b1;
        repeat (8) tick();

        // Timeout on the WAIT_CYCLES=15 / TIMEOUT=8 instance
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        ps_n = 1'b0; ior_n = 1'b0;
        repeat (11) tick();
        check("to clk11 timeout", int'(timeout_t), 0);
        check("to clk11 iogt",    int'(iogt_t), 0);
        tick();
        check("to clk12 timeout", int'(timeout_t), 1);
        check("to clk12 iogt",    int'(iogt_t), 1);
        check("to clk12 cyc",     int'(cyc_t), 1);
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        check("to cleared", int'(timeout_t), 0);
        ps_n = 1'b1; ior_n = 1'b1;
        repeat (6) tick();
        ps_n = 1'b0; ior_n = 1'b0;
        repeat (11) tick();
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        check("to set beats clear", int'(timeout_t), 1);
        tick();
        check("to sticky", int'(timeout_t), 1);
        ps_n = 1'b1; ior_n = 1'b1;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/podule_cycle.md
Name: podule_cycle

Overview:
- Podule bus cycle controller upstream of the address decoder.
- Synchronises the asynchronous podule strobes (select, read, write) into the FPGA clock domain and latches the address for the decoder.
- Issues single-cycle read/write strobes to the selected peripheral.
- Holds the host in wait (iogt low) until the access has completed.

Parameters:
- WAIT_CYCLES, 4, clocks between the strobe and the release of iogt (1..15). Gives slow peripherals time to settle data.
- TIMEOUT, 255, clocks in ACTIVE or WAIT before a forced release (8-bit counter).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- ps_n  input  1  podule select from host, asynchronous, active low
- ior_n  input  1  host read strobe, asynchronous, active low
- iow_n  input  1  host write strobe, asynchronous, active low
- la  input  12  host address bits [13:2], asynchronous
- a  output  12  latched address [13:2], feeds the decoder
- cyc  output  1  high while a latched cycle is in progress; qualifies the decoder chip selects
- rd_stb  output  1  one-clock read strobe
- wr_stb  output  1  one-clock write strobe
- iogt  output  1  host ready, open-drain style; 0 = hold the host
- timeout  output  1  sticky flag, set when a forced release occurs
- timeout_clr  input  1  clears timeout

Behaviour:
- Synchronisers:
  - ps_n, ior_n and iow_n each pass through two flip-flops. Define the synchronised signals as sel = ~ps_n_s2, rd = ~ior_n_s2, wr = ~iow_n_s2.
  - la is not synchronised. It is sampled only in the LATCH transition, after sel has been stable for 2 clocks, so the address is settled.
- Reset values: a=0, cyc=0, rd_stb=0, wr_stb=0, iogt=1, timeout=0, state=IDLE, counters=0.
- IDLE:
  - iogt=1, cyc=0.
  - sel & (rd|wr) -> go to LATCH.
  - If rd and wr are both asserted: treat as read; no wr_stb is issued.
- LATCH (1 clock):
  - a<=la, cyc<=1, iogt<=0.
  - Record the direction (dir=1 for write).
  - Go to ACTIVE.
- ACTIVE (1 clock):
  - Pulse rd_stb (dir=0) or wr_stb (dir=1) high for exactly this clock.
  - Load wait counter with WAIT_CYCLES-1.
  - Go to WAIT.
- WAIT:
  - Decrement the counter. At 0, go to RELEASE.
  - The peripheral must present read data by the end of WAIT.
- RELEASE:
  - iogt=1, cyc stays 1, a held.
  - Stay until the strobe for the recorded direction is released (rd=0 for a read, wr=0 for a write), or sel=0. Then go to IDLE, where cyc<=0.
  - A new strobe is accepted only after a pass through IDLE. No back-to-back cycle may start without deassertion.
- Latency:
  - Host strobe edge to rd_stb/wr_stb: 4 clocks (2 sync + LATCH + ACTIVE).
  - Strobe to iogt release: 4 + WAIT_CYCLES clocks.
- Abort:
  - sel or the active strobe drops during LATCH, ACTIVE or WAIT -> go to IDLE next clock, with iogt=1 and cyc=0.
  - A strobe already issued is not retracted. No further strobe is issued.
- Timeout:
  - An 8-bit counter runs while in ACTIVE or WAIT. On reaching TIMEOUT: set timeout=1 and go to RELEASE.
  - Only reachable if WAIT_CYCLES > TIMEOUT-1. This is a guard against a misconfigured WAIT_CYCLES.
  - timeout_clr clears the flag. If set and clear occur in the same clock, set wins.
- Reset mid-cycle: all state returns to reset values on the next clock edge. iogt=1, so the host is never left stalled.
- rd_stb and wr_stb are never high in the same clock, and each is high for at most one clock per host cycle.

Test Plan:
- Reset: hold rst 3 clocks during an active write -> iogt=1, cyc=0, a=0, no strobes afterwards until a new ps_n/iow_n assertion.
- Read: la=0x900 (IDE cmd region), ps_n=0, ior_n=0 at clock 0, WAIT_CYCLES=4 ->
  - a=0x900 from clock 3.
  - rd_stb high only at clock 4.
  - iogt low from clock 3 to 7, high at clock 8.
  - Release ior_n -> cyc=0 two or three clocks later.
- Write: la=0xC00 (flash page latch), iow_n=0 -> a single wr_stb at clock 4, rd_stb never high, a stable until IDLE.
- Held strobe: keep ior_n low for 50 clocks after the iogt release -> exactly one rd_stb. Release and re-assert -> a second rd_stb 4 clocks later.
- Abort: drop ps_n at clock 5 (in WAIT) -> IDLE at clock 8 (after sync), iogt=1, cyc=0, no timeout.
- Timeout: WAIT_CYCLES=15, TIMEOUT=8 ->
  - timeout=1 and iogt=1 after 8 clocks in ACTIVE/WAIT.
  - Pulse timeout_clr -> timeout=0.
  - Simultaneous set and clear -> timeout=1.
